booth_mul_ctrl: RTL
===================

Name: booth_mul_ctrl

Overview:
- Multi-cycle signed radix-2 Booth multiplier sequencer for the phase-1 datapath; computes HI:LO = multiplicand × multiplier for the MUL instruction.
- Owns one internal (WIDTH+1)-bit ripple/CLA adder instance and sequences it one add/subtract/skip decision per clock, so no WIDTH×WIDTH array multiplier is needed.
- Sits beside the ALU; the control unit pulses in_start and waits for out_done before latching HI/LO into the register file.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- clr  input  1  synchronous active-low reset; sampled on the rising edge of clk
- in_start  input  1  request; sampled only in IDLE
- in_multiplicand  input  WIDTH  signed two's-complement M, captured on accepted start
- in_multiplier  input  WIDTH  signed two's-complement Q, captured on accepted start
- out_busy  output  1  high while an operation is in RUN
- out_done  output  1  one-cycle pulse, result valid
- out_HI  output  WIDTH  upper half of product
- out_LO  output  WIDTH  lower half of product

Behaviour:
- Reset (clr=0 at edge): state=IDLE, counter=0, internal regs=0, out_busy=0, out_done=0, out_HI=0, out_LO=0. Reset overrides everything, including mid-RUN; the partial result is discarded, out_HI/LO are cleared, and no done pulse is produced.
- Internal regs: M_reg (WIDTH+1, sign-extended M), A (WIDTH+1), Q_reg (WIDTH), q_m1 (1), counter (ceil(log2 WIDTH) bits).
- IDLE: in_start=1 at edge k -> M_reg={M[WIDTH-1],M}, A=0, Q_reg=multiplier, q_m1=0, counter=0, state=RUN, out_busy=1. in_start=0 -> hold.
- RUN, one iteration per edge on {Q_reg[0],q_m1}:
  - 01: S = A + M_reg
  - 10: S = A + ~M_reg + 1, with adder Cin=1
  - 00/11: S = A
  - Then arithmetic shift right of {S,Q_reg,q_m1} by 1, with S[WIDTH] replicated into the MSB. Adder carry-out is ignored.
  - counter increments each iteration.
- Last iteration (counter==WIDTH-1, edge k+WIDTH): out_LO = shifted Q_reg, out_HI = shifted A[WIDTH-1:0], out_done=1, out_busy=0, state=DONE.
- DONE: at edge k+WIDTH+1 -> out_done=0, state=IDLE. in_start in DONE is ignored. The earliest next accept is edge k+WIDTH+2.
- in_start during RUN or DONE is ignored; captured operands are unaffected by input changes after acceptance.
- out_HI/out_LO are registered and hold the last result until the next completion or reset; an accepted start does not clear them.
- out_busy=1 exactly WIDTH cycles per operation. Start-to-done latency is WIDTH edges, and out_done is visible in the cycle after edge k+WIDTH.
- The (WIDTH+1)-bit A guarantees no overflow, including M = -2^(WIDTH-1). The result is the exact 2*WIDTH-bit signed product for all operand pairs.
- Simultaneous clr=0 and in_start=1: reset wins; stay IDLE.

Test Plan:
- Reset, then M=7, Q=3, start -> out_busy high 32 cycles; out_done pulses once; HI=0x00000000, LO=0x00000015; out_done low next cycle.
- M=0xFFFFFFF9 (-7), Q=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). M=0xFFFFFFFF, Q=0xFFFFFFFF -> HI=0, LO=1.
- M=Q=0x80000000 -> HI=0x40000000, LO=0x00000000 (no overflow). M=0x80000000, Q=0x7FFFFFFF -> HI=0xC0000000, LO=0x80000000.
- Start 7×3; at cycle 10 of RUN, pulse in_start with new operands 5×5 and change inputs -> still exactly one done with LO=0x15; no second operation begins.
- clr=0 at RUN cycle 16 of 7×3 -> out_busy=0, HI/LO=0, no done pulse. Start 2×2 after release -> LO=4 after 32 cycles.
- Back-to-back: hold in_start high continuously with 6×7 then 9×9 -> done pulses separated by 34 cycles; LO=0x2A, then LO=0x51. HI/LO hold 0x2A between the pulses.

Source files
------------

// File: rtl/booth_mul_ctrl.sv
// Signed radix-2 Booth multiplier sequencer: HI:LO = multiplicand * multiplier.
// Latency: WIDTH clocks from accepted in_start to the out_done pulse, then one DONE cycle.
// Backpressure: none; in_start is only sampled in IDLE and ignored while RUN or DONE.

// (W)-bit adder shared by every Booth iteration; carry-out is not needed
// because the accumulator is already one bit wider than the operands.
module booth_mul_add #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  // Single carry-propagate add with carry-in used for the two's-complement subtract.
  assign sum = a + b + W'(cin);

endmodule

module booth_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_multiplicand,
  input  logic [WIDTH-1:0] in_multiplier,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_HI,
  output logic [WIDTH-1:0] out_LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;      // sign-extended multiplicand
  logic [WIDTH:0]   a_q, a_d;      // accumulator, one guard bit wide
  logic [WIDTH-1:0] q_q, q_d;      // multiplier, shifted out LSB first
  logic             qm1_q, qm1_d;  // Booth history bit
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH-1:0] q_shift;

  // Booth recoding of {Q[0], q_-1}: 01 adds M, 10 subtracts M, 00/11 pass A through.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    unique case ({q_q[0], qm1_q})
      2'b01:   add_b = m_q;
      2'b10: begin
        add_b   = ~m_q;
        add_cin = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  booth_mul_add #(.W(WIDTH + 1)) u_add (
    .a   (a_q),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  // Arithmetic right shift of {S, Q, q_-1}; the sign bit of S is replicated.
  always_comb begin
    a_shift = {add_sum[WIDTH], add_sum[WIDTH:1]};
    q_shift = {add_sum[0], q_q[WIDTH-1:1]};
  end

  // Sequencer next-state: capture in IDLE, one Booth step per clock in RUN,
  // publish the product on the last step, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          m_d     = {in_multiplicand[WIDTH-1], in_multiplicand};
          a_d     = '0;
          q_d     = in_multiplier;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_shift;
        q_d   = q_shift;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          hi_d    = a_shift[WIDTH-1:0];
          lo_d    = q_shift;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status flags decode directly from the registered state.
  always_comb begin
    out_busy = (state_q == S_RUN);
    out_done = (state_q == S_DONE);
    out_HI   = hi_q;
    out_LO   = lo_q;
  end

endmodule
